// File: rtl/keypad_pkg.sv
// Key codes and session state encodings shared by the keypad scanner, the amount
// entry controller and the charge controller.
package keypad_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_START     = 4'd10;
    localparam logic [3:0] KEY_CLEAR     = 4'd11;
    localparam logic [3:0] KEY_CONFIRM   = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ENTRY     = 2'd1,
        ST_CONFIRMED = 2'd2
    } state_e;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= KEY_DIGIT_MAX;
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [3:0] hi, input logic [3:0] lo);
        return 7'(hi) * 7'd10 + 7'(lo);
    endfunction

endpackage

// File: rtl/amount_entry_controller_key_event_detect.sv
// Turns the scanner's press level into a one-cycle key event and presents the key
// code for that cycle.
module key_event_detect
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_i,
    input  logic       press_i,
    input  logic [3:0] key_value_i,
    output logic       key_evt_o,
    output logic [3:0] key_code_o
);

    logic press_q;

    // Resetting to 1 means a key still held through reset needs a fresh press.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            press_q <= 1'b1;
        end else begin
            press_q <= press_i;
        end
    end

    assign key_evt_o  = press_i & ~press_q;
    assign key_code_o = key_evt_o ? key_value_i : 4'd0;

endmodule

// File: rtl/amount_entry_controller.sv
// Session sequencer: collects up to two decimal digits, validates the amount on
// confirm, holds it for the charge controller and aborts abandoned entries.
module amount_entry_controller
    import keypad_pkg::*;
#(
    parameter int MAX_AMOUNT  = 20,
    parameter int TIMEOUT_CYC = 10000,
    parameter int TMR_W       = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    input  logic [3:0] key_value,
    input  logic       charge_done,
    output logic [1:0] state,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic [6:0] amount,
    output logic       amount_valid,
    output logic       err
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [6:0]       AMT_MAX  = 7'(MAX_AMOUNT);

    state_e           state_q;
    logic [3:0]       digit_hi_q;
    logic [3:0]       digit_lo_q;
    logic [6:0]       amount_q;
    logic [1:0]       count_q;
    logic [TMR_W-1:0] timer_q;
    logic             amount_valid_q;
    logic             err_q;

    logic             key_evt;
    logic [3:0]       key_code;

    key_event_detect u_key_event_detect (
        .clk         (clk),
        .rst_i       (rst_n),
        .press_i     (press),
        .key_value_i (key_value),
        .key_evt_o   (key_evt),
        .key_code_o  (key_code)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q        <= ST_IDLE;
            digit_hi_q     <= 4'd0;
            digit_lo_q     <= 4'd0;
            amount_q       <= 7'd0;
            count_q        <= 2'd0;
            timer_q        <= '0;
            amount_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            amount_valid_q <= 1'b0;
            err_q          <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (key_evt && key_code == KEY_START) begin
                        state_q    <= ST_ENTRY;
                        digit_hi_q <= 4'd0;
                        digit_lo_q <= 4'd0;
                        amount_q   <= 7'd0;
                        count_q    <= 2'd0;
                    end
                end
                ST_ENTRY: begin
                    if (key_evt) begin
                        timer_q <= '0;
                        if (is_digit(key_code)) begin
                            if (count_q < 2'd2) begin
                                // amount follows the shifted digits in the same edge
                                digit_hi_q <= digit_lo_q;
                                digit_lo_q <= key_code;
                                amount_q   <= bcd2bin(digit_lo_q, key_code);
                                count_q    <= count_q + 2'd1;
                            end
                        end else if (key_code == KEY_START || key_code == KEY_CLEAR) begin
                            digit_hi_q <= 4'd0;
                            digit_lo_q <= 4'd0;
                            amount_q   <= 7'd0;
                            count_q    <= 2'd0;
                        end else if (key_code == KEY_CONFIRM && amount_q != 7'd0) begin
                            if (amount_q <= AMT_MAX) begin
                                state_q        <= ST_CONFIRMED;
                                amount_valid_q <= 1'b1;
                            end else begin
                                err_q      <= 1'b1;
                                digit_hi_q <= 4'd0;
                                digit_lo_q <= 4'd0;
                                amount_q   <= 7'd0;
                                count_q    <= 2'd0;
                            end
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_q    <= ST_IDLE;
                        err_q      <= 1'b1;
                        timer_q    <= '0;
                        digit_hi_q <= 4'd0;
                        digit_lo_q <= 4'd0;
                        amount_q   <= 7'd0;
                        count_q    <= 2'd0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_CONFIRMED: begin
                    timer_q <= '0;
                    if (charge_done) begin
                        state_q    <= ST_IDLE;
                        digit_hi_q <= 4'd0;
                        digit_lo_q <= 4'd0;
                        amount_q   <= 7'd0;
                        count_q    <= 2'd0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    timer_q    <= '0;
                    digit_hi_q <= 4'd0;
                    digit_lo_q <= 4'd0;
                    amount_q   <= 7'd0;
                    count_q    <= 2'd0;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign digit_hi     = digit_hi_q;
    assign digit_lo     = digit_lo_q;
    assign amount       = amount_q;
    assign amount_valid = amount_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_amount_entry_controller.sv
// Directed session scenarios followed by random key traffic, every cycle compared
// against a digit-list reference model of the entry session.
module tb_amount_entry_controller;

    localparam int MAX_AMT = 20;
    localparam int T_CYC   = 300;
    localparam int T_W     = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       press;
    logic [3:0] key_value;
    logic       charge_done;
    logic [1:0] state;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;
    logic [6:0] amount;
    logic       amount_valid;
    logic       err;

    int checks   = 0;
    int failures = 0;

    amount_entry_controller #(
        .MAX_AMOUNT  (MAX_AMT),
        .TIMEOUT_CYC (T_CYC),
        .TMR_W       (T_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .press        (press),
        .key_value    (key_value),
        .charge_done  (charge_done),
        .state        (state),
        .digit_hi     (digit_hi),
        .digit_lo     (digit_lo),
        .amount       (amount),
        .amount_valid (amount_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Reference model: session phase, list of entered digits, idle-cycle count.
    int m_phase;
    int m_digs[$];
    int m_idle;
    bit m_prev;
    bit m_valid;
    bit m_err;

    function automatic int m_value();
        if (m_digs.size() == 0) return 0;
        if (m_digs.size() == 1) return m_digs[0];
        return m_digs[0] * 10 + m_digs[1];
    endfunction

    function automatic int m_hi();
        return (m_digs.size() == 2) ? m_digs[0] : 0;
    endfunction

    function automatic int m_lo();
        return (m_digs.size() > 0) ? m_digs[m_digs.size()-1] : 0;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_digs.delete();
        m_idle  = 0;
        m_prev  = 1'b1;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit p, input int k, input bit d);
        bit evt;
        evt     = p && !m_prev;
        m_prev  = p;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (m_phase == 0) begin
            m_idle = 0;
            if (evt && k == 10) begin
                m_phase = 1;
                m_digs.delete();
            end
        end else if (m_phase == 1) begin
            if (evt) begin
                m_idle = 0;
                if (k <= 9) begin
                    if (m_digs.size() < 2) m_digs.push_back(k);
                end else if (k == 10 || k == 11) begin
                    m_digs.delete();
                end else if (k == 12) begin
                    if (m_value() >= 1 && m_value() <= MAX_AMT) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                    end else if (m_value() > MAX_AMT) begin
                        m_err = 1'b1;
                        m_digs.delete();
                    end
                end
            end else if (m_idle == T_CYC - 1) begin
                m_phase = 0;
                m_err   = 1'b1;
                m_idle  = 0;
                m_digs.delete();
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
            if (d) begin
                m_phase = 0;
                m_digs.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":state"},        8'(state),        8'(m_phase));
        chk({ctx, ":digit_hi"},     8'(digit_hi),     8'(m_hi()));
        chk({ctx, ":digit_lo"},     8'(digit_lo),     8'(m_lo()));
        chk({ctx, ":amount"},       8'(amount),       8'(m_value()));
        chk({ctx, ":amount_valid"}, 8'(amount_valid), 8'(m_valid));
        chk({ctx, ":err"},          8'(err),          8'(m_err));
    endtask

    task automatic step(input string ctx, input bit p, input int k, input bit d);
        @(negedge clk);
        press       = p;
        key_value   = 4'(k);
        charge_done = d;
        model_step(p, k, d);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic tap(input string ctx, input int k);
        step(ctx, 1'b1, k, 1'b0);
        step(ctx, 1'b0, k, 1'b0);
    endtask

    bit cur_p;
    int cur_k;
    int guard;

    initial begin
        rst_n       = 1'b1;
        press       = 1'b0;
        key_value   = 4'd0;
        charge_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b0;

        // Basic session: START, 1, 5, CONFIRM, charge_done
        tap("idle_digit", 5);
        tap("start", 10);
        chk("start_state", 8'(state), 8'd1);
        tap("d1", 1);
        tap("d5", 5);
        chk("amt15", 8'(amount), 8'd15);
        step("confirm15", 1'b1, 12, 1'b0);
        chk("valid_pulse", 8'(amount_valid), 8'd1);
        step("confirm15_rel", 1'b0, 12, 1'b0);
        chk("valid_one_cycle", 8'(amount_valid), 8'd0);
        step("done_key_clash", 1'b1, 3, 1'b1);
        chk("done_idle", 8'(state), 8'd0);
        step("rel", 1'b0, 3, 1'b0);

        // Over-limit confirm, then a valid single digit
        tap("start2", 10);
        tap("d9a", 9);
        tap("d9b", 9);
        step("confirm99", 1'b1, 12, 1'b0);
        chk("err99", 8'(err), 8'd1);
        step("confirm99_rel", 1'b0, 12, 1'b0);
        tap("d7", 7);
        step("confirm7", 1'b1, 12, 1'b0);
        chk("amt7_state", 8'(state), 8'd2);
        step("confirm7_rel", 1'b0, 12, 1'b0);
        tap("confirmed_key", 4);
        tap("confirmed_clear", 11);
        step("done7", 1'b0, 0, 1'b1);

        // Third digit ignored, clear, confirm on zero, boundary amount 20 and 21
        tap("start3", 10);
        tap("d1b", 1);
        tap("d2", 2);
        tap("d3_ignored", 3);
        chk("amt12", 8'(amount), 8'd12);
        tap("clear", 11);
        tap("confirm0", 12);
        chk("confirm0_state", 8'(state), 8'd1);
        tap("d2b", 2);
        tap("d1c", 1);
        tap("confirm21", 12);
        tap("unused13", 13);
        tap("d2c", 2);
        tap("d0", 0);
        tap("confirm20", 12);
        chk("amt20_state", 8'(state), 8'd2);
        step("done20", 1'b0, 0, 1'b1);

        // Held key yields one event
        tap("start4", 10);
        for (int i = 0; i < 200; i++) step("hold4", 1'b1, 4, 1'b0);
        step("hold4_rel", 1'b0, 4, 1'b0);
        chk("hold_lo", 8'(digit_lo), 8'd4);
        chk("hold_hi", 8'(digit_hi), 8'd0);

        // Timeout, then key event in the final cycle
        guard = 0;
        while (m_phase == 1 && guard < T_CYC + 10) begin
            step("timeout", 1'b0, 0, 1'b0);
            guard++;
        end
        chk("timeout_reached", 8'(state), 8'd0);
        tap("start5", 10);
        guard = 0;
        while (m_idle != T_CYC - 1 && guard < T_CYC + 10) begin
            step("pre_timeout", 1'b0, 0, 1'b0);
            guard++;
        end
        step("last_cycle_key", 1'b1, 8, 1'b0);
        chk("no_timeout", 8'(state), 8'd1);
        chk("no_timeout_err", 8'(err), 8'd0);
        step("last_rel", 1'b0, 8, 1'b0);

        // Async reset with digit 3 held mid-entry
        step("hold3", 1'b1, 3, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) step("held_after_reset", 1'b1, 3, 1'b0);
        // START held through reset must not start a session either
        step("start_hold", 1'b1, 10, 1'b0);
        step("start_hold2", 1'b0, 10, 1'b0);
        step("start_hold3", 1'b1, 10, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_all("async_reset2");
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) step("start_held", 1'b1, 10, 1'b0);
        chk("start_held_idle", 8'(state), 8'd0);
        step("start_rel", 1'b0, 10, 1'b0);
        tap("start_again", 10);
        chk("start_again_state", 8'(state), 8'd1);

        // Random key traffic
        cur_p = 1'b0;
        cur_k = 0;
        for (int i = 0; i < 4000; i++) begin
            if (cur_p) begin
                if ($urandom_range(0, 2) == 0) cur_p = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                cur_p = 1'b1;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: cur_k = $urandom_range(0, 9);
                    5, 6:          cur_k = 12;
                    7:             cur_k = 10;
                    8:             cur_k = 11;
                    default:       cur_k = $urandom_range(13, 15);
                endcase
            end
            step("random", cur_p, cur_k, ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
